// File: rtl/reaction_timer.sv
// F1 start-lights reaction timer: times lights-out to button press in prescaled
// ticks, flags false starts and saturates at the counter maximum.
module reaction_timer #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] N,
  input  logic [7:0]       lights,
  input  logic             btn,
  output logic [CNT_W-1:0] react_time,
  output logic             valid,
  output logic             false_start,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_TIMING = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_s1, r_s2, r_s3;
  logic               w_press, w_tick, w_cnt_max, w_lights_off, w_lights_full;
  logic [CNT_W-1:0]   r_count, w_count_nxt, r_react, w_react_nxt;
  logic [DIV_W-1:0]   r_presc, w_presc_nxt;
  logic               r_seen_full, w_seen_full_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_false_start, w_false_start_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_busy, w_busy_nxt;

  assign w_press       = r_s2 & ~r_s3;
  assign w_tick        = (r_presc == N);
  assign w_cnt_max     = (r_count == {CNT_W{1'b1}});
  assign w_lights_off  = (lights == 8'h00);
  assign w_lights_full = (lights == 8'hFF);

  // Button synchroniser plus edge-detect delay flop
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; a press always outranks lights and tick events
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_lights_off) w_state_nxt = S_ARMED;
                else               w_state_nxt = S_IDLE;
      S_ARMED:  if (w_press)           w_state_nxt = S_FAULT;
                else if (w_lights_off) w_state_nxt = r_seen_full ? S_TIMING : S_IDLE;
                else                   w_state_nxt = S_ARMED;
      S_TIMING: if (w_press)                   w_state_nxt = S_DONE;
                else if (!w_lights_off)        w_state_nxt = S_ARMED;
                else if (w_tick && w_cnt_max)  w_state_nxt = S_DONE;
                else                           w_state_nxt = S_TIMING;
      S_DONE:   w_state_nxt = S_IDLE;
      S_FAULT:  if (w_lights_off) w_state_nxt = S_IDLE;
                else              w_state_nxt = S_FAULT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_count_nxt       = r_count;
    w_presc_nxt       = r_presc;
    w_react_nxt       = r_react;
    w_seen_full_nxt   = r_seen_full;
    w_valid_nxt       = 1'b0;
    w_false_start_nxt = r_false_start;
    w_timeout_nxt     = r_timeout;
    w_busy_nxt        = (w_state_nxt == S_ARMED) || (w_state_nxt == S_TIMING);
    case (r_state)
      S_IDLE: begin
        if (!w_lights_off) begin
          w_false_start_nxt = 1'b0;
          w_timeout_nxt     = 1'b0;
          w_seen_full_nxt   = 1'b0;
        end else begin
          w_seen_full_nxt   = r_seen_full;
        end
      end
      S_ARMED: begin
        if (w_press) begin
          w_false_start_nxt = 1'b1;
        end else if (w_lights_off) begin
          w_count_nxt = {CNT_W{1'b0}};
          w_presc_nxt = {DIV_W{1'b0}};
        end else if (w_lights_full) begin
          w_seen_full_nxt = 1'b1;
        end else begin
          w_seen_full_nxt = r_seen_full;
        end
      end
      S_TIMING: begin
        if (w_press) begin
          w_react_nxt   = r_count;
          w_valid_nxt   = 1'b1;
          w_timeout_nxt = 1'b0;
        end else if (!w_lights_off) begin
          w_seen_full_nxt = 1'b0;
        end else if (w_tick) begin
          w_presc_nxt = {DIV_W{1'b0}};
          if (w_cnt_max) begin
            w_react_nxt   = {CNT_W{1'b1}};
            w_timeout_nxt = 1'b1;
            w_valid_nxt   = 1'b1;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end else begin
          w_presc_nxt = r_presc + DIV_W'(1);
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count       <= {CNT_W{1'b0}};
      r_presc       <= {DIV_W{1'b0}};
      r_react       <= {CNT_W{1'b0}};
      r_seen_full   <= 1'b0;
      r_valid       <= 1'b0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_count       <= w_count_nxt;
      r_presc       <= w_presc_nxt;
      r_react       <= w_react_nxt;
      r_seen_full   <= w_seen_full_nxt;
      r_valid       <= w_valid_nxt;
      r_false_start <= w_false_start_nxt;
      r_timeout     <= w_timeout_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign react_time  = r_react;
  assign valid       = r_valid;
  assign false_start = r_false_start;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: directed scenarios with literal
// expectations plus randomized rounds compared every cycle against a model.
module tb_reaction_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] N = 16'd0;
  logic [7:0]  lights = 8'hFF;
  logic        btn = 1'b1;
  logic [7:0]  react_time;
  logic        valid, false_start, timeout, busy;

  reaction_timer #(.CNT_W(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .N(N), .lights(lights), .btn(btn),
    .react_time(react_time), .valid(valid), .false_start(false_start),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: elapsed-cycle arithmetic instead of a prescaler/counter
  localparam int M_IDLE = 0, M_ARMED = 1, M_TIMING = 2, M_DONE = 3, M_FAULT = 4;
  int       m_mode = M_IDLE;
  int       m_react = 0;
  bit       m_valid = 0, m_fs = 0, m_to = 0, m_seen = 0;
  bit [2:0] m_hist = 3'b000;
  int       cyc = 0, t0 = 0, nlat = 0, m_e = 0;
  bit       m_press = 0, started = 0;

  initial forever begin
    @(posedge clk);
    started = 1;
    if (!rst) begin
      m_mode = M_IDLE; m_react = 0; m_valid = 0; m_fs = 0; m_to = 0;
      m_seen = 0; m_hist = 3'b000;
    end else begin
      m_press = m_hist[1] & ~m_hist[2];
      m_valid = 0;
      case (m_mode)
        M_IDLE: if (lights != 8'h00) begin
          m_mode = M_ARMED; m_fs = 0; m_to = 0; m_seen = 0;
        end
        M_ARMED: begin
          if (m_press) begin
            m_mode = M_FAULT; m_fs = 1;
          end else if (lights == 8'h00) begin
            if (m_seen) begin m_mode = M_TIMING; t0 = cyc; nlat = int'(N); end
            else m_mode = M_IDLE;
          end else if (lights == 8'hFF) m_seen = 1;
        end
        M_TIMING: begin
          m_e = cyc - t0;
          if (m_press) begin
            m_react = (m_e - 1) / (nlat + 1); m_valid = 1; m_to = 0; m_mode = M_DONE;
          end else if (lights != 8'h00) begin
            m_mode = M_ARMED; m_seen = 0;
          end else if (m_e == 256 * (nlat + 1)) begin
            m_react = 255; m_to = 1; m_valid = 1; m_mode = M_DONE;
          end
        end
        M_DONE: m_mode = M_IDLE;
        M_FAULT: if (lights == 8'h00) m_mode = M_IDLE;
        default: m_mode = M_IDLE;
      endcase
      m_hist = {m_hist[1:0], btn};
    end
    cyc++;
  end

  // Per-cycle comparison against the model on the falling edge
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("react_time", 32'(react_time), 32'(m_react));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("false_start", 32'(false_start), 32'(m_fs));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("busy", 32'(busy), 32'((m_mode == M_ARMED) || (m_mode == M_TIMING)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Light the bar 01..FF then switch off; returns just after edge E0
  task automatic start_round(input int n);
    N = 16'(n);
    for (int i = 1; i <= 8; i++) begin
      lights = 8'((1 << i) - 1);
      step(1);
    end
    lights = 8'h00;
    step(1);
  endtask

  task automatic wait_valid(input int maxc, output bit seen);
    seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (valid === 1'b1) seen = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press_round(input int n, input int d, output bit seen, output int rt);
    start_round(n);
    step(d - 1);
    btn = 1'b1;
    wait_valid(d + 600, seen);
    rt = int'(react_time);
    btn = 1'b0;
    step(3);
  endtask

  bit seen;
  int rt;

  initial begin
    // Reset held with button pressed and lights full
    step(2);
    @(negedge clk);
    chk("rst_react", 32'(react_time), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fs", 32'(false_start), 32'd0);
    rst = 1'b1; btn = 1'b0; lights = 8'h00;
    step(3);
    chk("idle_busy", 32'(busy), 32'd0);

    press_round(0, 20, seen, rt);
    chk("t2_seen", 32'(seen), 32'd1);
    chk("t2_react", 32'(rt), 32'd21);
    chk("t2_timeout", 32'(timeout), 32'd0);

    press_round(4, 48, seen, rt);
    chk("t3_seen", 32'(seen), 32'd1);
    chk("t3_react", 32'(rt), 32'd9);

    // False start while lights 0x07
    N = 16'd0;
    lights = 8'h01; step(1);
    lights = 8'h03; step(1);
    lights = 8'h07; step(1);
    btn = 1'b1; step(4);
    @(negedge clk);
    chk("t4_fs", 32'(false_start), 32'd1);
    chk("t4_novalid", 32'(valid), 32'd0);
    chk("t4_react_kept", 32'(react_time), 32'd9);
    @(posedge clk); #1;
    btn = 1'b0; lights = 8'h00; step(1);
    chk("t4_fs_hold", 32'(false_start), 32'd1);
    lights = 8'h01; step(1);
    @(negedge clk);
    chk("t4_fs_clear", 32'(false_start), 32'd0);
    @(posedge clk); #1;
    lights = 8'h00; step(3);

    // Saturation without a press
    start_round(0);
    wait_valid(300, seen);
    chk("t5_seen", 32'(seen), 32'd1);
    chk("t5_react", 32'(react_time), 32'd255);
    chk("t5_timeout", 32'(timeout), 32'd1);
    step(2);

    // Reset during TIMING
    start_round(0);
    step(9);
    rst = 1'b0; step(1);
    @(negedge clk);
    chk("t6_react", 32'(react_time), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; step(2);
    press_round(0, 5, seen, rt);
    chk("t6_next_react", 32'(rt), 32'd6);

    // Randomized structured rounds
    for (int r = 0; r < 20; r++) begin
      int n, d;
      n = $urandom_range(0, 2);
      d = $urandom_range(1, 200);
      press_round(n, d, seen, rt);
      chk("rand_round_seen", 32'(seen), 32'd1);
    end

    // Free-running random lights/button activity
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 4))
          0: lights = 8'h01;
          1: lights = 8'h03;
          2: lights = 8'hFF;
          default: lights = 8'h00;
        endcase
      end
      if ($urandom_range(0, 15) == 0) btn = ~btn;
      if (m_mode == M_IDLE && $urandom_range(0, 31) == 0) N = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) rst = 1'b0;
      else rst = 1'b1;
      step(1);
    end
    rst = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
